// File: rtl/mbist_march_ctrl.sv
// mbist_march_ctrl: March C- memory BIST controller.
// Runs M0 up w0; M1 up r0,w1; M2 up r1,w0; M3 down r0,w1; M4 down r1,w0; M5 up r0
// over a 2^ADDR_W deep, DATA_W wide single-port memory with one-cycle read latency.
// Optional first-fail log (fail_addr/fail_elem/fail_cnt): define MBIST_FAIL_LOG_EN.
module mbist_march_ctrl #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              pattern_sel,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              fail,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_elem,
   output logic [7:0]        fail_cnt
);

   localparam int unsigned       HALF_W    = DATA_W / 2;
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   // Element states are encoded 0..5 so the element index is the state code.
   typedef enum logic [2:0] {
      S_M0   = 3'd0,
      S_M1   = 3'd1,
      S_M2   = 3'd2,
      S_M3   = 3'd3,
      S_M4   = 3'd4,
      S_M5   = 3'd5,
      S_IDLE = 3'd6,
      S_DONE = 3'd7
   } state_t;

   typedef enum logic {
      PH_R = 1'b0,
      PH_W = 1'b1
   } phase_t;

   state_t              state_q, state_d;
   phase_t              phase_q, phase_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                pat_q, pat_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                fail_q, fail_d;
   logic                we_q, we_d;
   logic                re_q, re_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                accept_c;
   logic                cmp_c;
   logic                last_c;
   logic                miss_c;
   logic [DATA_W-1:0]   exp_c;

   // Background word: solid (all 0/1) or checkerboard alternating with address parity.
   function automatic logic [DATA_W-1:0] bg_word(input logic pat,
                                                 input logic [ADDR_W-1:0] a,
                                                 input logic v);
      logic [DATA_W-1:0] w;
      if (pat) begin
         w = a[0] ? {HALF_W{2'b10}} : {HALF_W{2'b01}};
      end else begin
         w = '0;
      end
      return v ? ~w : w;
   endfunction

   // Read/write elements (two cycles per address).
   function automatic logic is_rw(input state_t s);
      return (s == S_M1) || (s == S_M2) || (s == S_M3) || (s == S_M4) || (s == S_M5);
   endfunction

   // Elements that walk the address space downwards.
   function automatic logic elem_down(input state_t s);
      return (s == S_M3) || (s == S_M4);
   endfunction

   // Value each element expects to read back.
   function automatic logic rd_val(input state_t s);
      return (s == S_M2) || (s == S_M4);
   endfunction

   // Value each element writes.
   function automatic logic wr_val(input state_t s);
      return (s == S_M1) || (s == S_M3);
   endfunction

   // Element sequencing.
   function automatic state_t next_elem(input state_t s);
      state_t n;
      case (s)
         S_M0:    n = S_M1;
         S_M1:    n = S_M2;
         S_M2:    n = S_M3;
         S_M3:    n = S_M4;
         S_M4:    n = S_M5;
         S_M5:    n = S_DONE;
         default: n = S_IDLE;
      endcase
      return n;
   endfunction

   // Next-state, address walk and registered-output next values.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      addr_d   = addr_q;
      pat_d    = pat_q;
      accept_c = 1'b0;
      cmp_c    = 1'b0;
      last_c   = elem_down(state_q) ? (addr_q == '0) : (addr_q == ADDR_LAST);

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d  = S_M0;
               phase_d  = PH_R;
               addr_d   = '0;
               pat_d    = pattern_sel;
               accept_c = 1'b1;
            end
         end
         S_M0: begin
            if (last_c) begin
               state_d = next_elem(state_q);
               addr_d  = '0;
            end else begin
               addr_d = addr_q + ADDR_W'(1);
            end
         end
         default: begin
            if (phase_q == PH_R) begin
               phase_d = PH_W;
            end else begin
               phase_d = PH_R;
               cmp_c   = 1'b1;
               if (last_c) begin
                  state_d = next_elem(state_q);
                  addr_d  = elem_down(state_d) ? ADDR_LAST : '0;
               end else if (elem_down(state_q)) begin
                  addr_d = addr_q - ADDR_W'(1);
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
               end
            end
         end
      endcase

      exp_c  = bg_word(pat_q, addr_q, rd_val(state_q));
      miss_c = cmp_c && (mem_rdata != exp_c);

      busy_d  = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d  = (state_d == S_DONE);
      we_d    = (state_d == S_M0) ||
                (is_rw(state_d) && (state_d != S_M5) && (phase_d == PH_W));
      re_d    = is_rw(state_d) && (phase_d == PH_R);
      wdata_d = (busy_d && (state_d != S_M5)) ? bg_word(pat_d, addr_d, wr_val(state_d)) : '0;
      fail_d  = accept_c ? 1'b0 : (fail_q | miss_c);
   end

   // State, address and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         phase_q <= PH_R;
         addr_q  <= '0;
         pat_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         fail_q  <= 1'b0;
         we_q    <= 1'b0;
         re_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         addr_q  <= addr_d;
         pat_q   <= pat_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         fail_q  <= fail_d;
         we_q    <= we_d;
         re_q    <= re_d;
         wdata_q <= wdata_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = we_q;
   assign mem_re    = re_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fail      = fail_q;

`ifdef MBIST_FAIL_LOG_EN
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [2:0]        fail_elem_q, fail_elem_d;
   logic [7:0]        fail_cnt_q, fail_cnt_d;

   // First-fail capture and saturating miscompare count.
   always_comb begin
      fail_addr_d = fail_addr_q;
      fail_elem_d = fail_elem_q;
      fail_cnt_d  = fail_cnt_q;
      if (accept_c) begin
         fail_addr_d = '0;
         fail_elem_d = '0;
         fail_cnt_d  = '0;
      end else if (miss_c) begin
         if (!fail_q) begin
            fail_addr_d = addr_q;
            fail_elem_d = 3'(state_q);
         end
         if (fail_cnt_q != 8'hFF) begin
            fail_cnt_d = fail_cnt_q + 8'd1;
         end
      end
   end

   // Fail log registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fail_addr_q <= '0;
         fail_elem_q <= '0;
         fail_cnt_q  <= '0;
      end else begin
         fail_addr_q <= fail_addr_d;
         fail_elem_q <= fail_elem_d;
         fail_cnt_q  <= fail_cnt_d;
      end
   end

   assign fail_addr = fail_addr_q;
   assign fail_elem = fail_elem_q;
   assign fail_cnt  = fail_cnt_q;
`else
   assign fail_addr = '0;
   assign fail_elem = '0;
   assign fail_cnt  = '0;
`endif

endmodule
